// File: rtl/breath_pwm_mc.sv
// Multi-channel PWM with a shared triangle "breathing" ramp.
// Duty and mode are shadowed at each period boundary so outputs never glitch mid-period.
module breath_pwm_mc #(
    parameter int CH   = 4,
    parameter int W    = 8,
    parameter int DIVW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2*CH-1:0]   mode,
    input  logic [CH*W-1:0]   duty_in,
    input  logic [DIVW-1:0]   step_div,
    output logic [CH-1:0]     pwm_out,
    output logic              period_tick
);

    localparam logic [W-1:0] CNT_MAX      = '1;
    localparam logic [1:0]   MODE_OFF     = 2'b00;
    localparam logic [1:0]   MODE_STATIC  = 2'b01;
    localparam logic [1:0]   MODE_BREATHE = 2'b10;
    localparam logic [1:0]   MODE_INV     = 2'b11;
    localparam logic         DIR_UP       = 1'b0;
    localparam logic         DIR_DOWN     = 1'b1;

    logic [W-1:0]    cnt;
    logic [DIVW-1:0] divcnt;
    logic [W-1:0]    r;
    logic            dir;
    logic [W-1:0]    shadow_duty [CH];
    logic [1:0]      shadow_mode [CH];

    logic            boundary;
    logic            ramp_step;
    logic [W-1:0]    r_next;
    logic            dir_next;
    logic [W-1:0]    eff_duty [CH];

    assign boundary  = en && (cnt == CNT_MAX);
    // >= rather than == so lowering step_div below divcnt steps at once instead of wrapping.
    assign ramp_step = boundary && (divcnt >= step_div);

    // Triangle ramp: turn around at the extremes so each extreme lasts exactly one step.
    always_comb begin
        r_next   = r;
        dir_next = dir;
        if (dir == DIR_UP) begin
            if (r == CNT_MAX) begin
                r_next   = r - 1'b1;
                dir_next = DIR_DOWN;
            end else begin
                r_next = r + 1'b1;
            end
        end else begin
            if (r == '0) begin
                r_next   = r + 1'b1;
                dir_next = DIR_UP;
            end else begin
                r_next = r - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            eff_duty[i] = '0;
            case (mode[2*i +: 2])
                MODE_STATIC:  eff_duty[i] = duty_in[W*i +: W];
                MODE_BREATHE: eff_duty[i] = r;
                MODE_INV:     eff_duty[i] = CNT_MAX - r;
                default:      eff_duty[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            divcnt      <= '0;
            r           <= '0;
            dir         <= DIR_UP;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                shadow_duty[i] <= '0;
                shadow_mode[i] <= MODE_OFF;
            end
        end else begin
            period_tick <= boundary;
            if (en) begin
                cnt <= cnt + 1'b1;
                // Compare uses the shadows of the current period, before any boundary update.
                for (int i = 0; i < CH; i++) begin
                    pwm_out[i] <= (shadow_mode[i] != MODE_OFF) && (cnt < shadow_duty[i]);
                end
            end else begin
                pwm_out <= '0;
            end
            if (boundary) begin
                for (int i = 0; i < CH; i++) begin
                    shadow_duty[i] <= eff_duty[i];
                    shadow_mode[i] <= mode[2*i +: 2];
                end
                if (ramp_step) begin
                    divcnt <= '0;
                    r      <= r_next;
                    dir    <= dir_next;
                end else begin
                    divcnt <= divcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_breath_pwm_mc.sv
// Directed bench for breath_pwm_mc: a W=8 instance for static/breathe/enable-gap/prescaler cases
// and a W=3 instance so full ramp turnarounds and a mid-ramp-down reset fit in a short run.
module tb_breath_pwm_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=8 instance
    logic        b_rst, b_en;
    logic [7:0]  b_mode;
    logic [31:0] b_duty;
    logic [15:0] b_step;
    logic [3:0]  b_pwm;
    logic        b_tick;

    // W=3 instance
    logic        s_rst, s_en;
    logic [7:0]  s_mode;
    logic [11:0] s_duty;
    logic [3:0]  s_step;
    logic [3:0]  s_pwm;
    logic        s_tick;

    breath_pwm_mc #(.CH(4), .W(8), .DIVW(16)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .duty_in(b_duty),
        .step_div(b_step), .pwm_out(b_pwm), .period_tick(b_tick)
    );

    breath_pwm_mc #(.CH(4), .W(3), .DIVW(4)) dut_s (
        .clk(clk), .rst(s_rst), .en(s_en), .mode(s_mode), .duty_in(s_duty),
        .step_div(s_step), .pwm_out(s_pwm), .period_tick(s_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Window monitor: per DUT and channel, count high samples between consecutive period ticks.
    // A window ends on the tick sample, which carries the compare of the last count of the period.
    logic [3:0] pwm_arr [2];
    logic       tick_arr [2];
    logic       rst_arr [2];
    assign pwm_arr[0]  = b_pwm;
    assign pwm_arr[1]  = s_pwm;
    assign tick_arr[0] = b_tick;
    assign tick_arr[1] = s_tick;
    assign rst_arr[0]  = b_rst;
    assign rst_arr[1]  = s_rst;

    int   acc [2][4];
    int   win [2][4];
    int   rise_acc [2];
    int   rise_win [2];
    logic prev0 [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_arr[d]) begin
                for (int i = 0; i < 4; i++) acc[d][i] <= 0;
                rise_acc[d] <= 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (tick_arr[d]) begin
                        win[d][i] <= acc[d][i] + int'(pwm_arr[d][i]);
                        acc[d][i] <= 0;
                    end else begin
                        acc[d][i] <= acc[d][i] + int'(pwm_arr[d][i]);
                    end
                end
                if (tick_arr[d]) begin
                    rise_win[d] <= rise_acc[d] + int'(pwm_arr[d][0] && !prev0[d]);
                    rise_acc[d] <= 0;
                end else begin
                    rise_acc[d] <= rise_acc[d] + int'(pwm_arr[d][0] && !prev0[d]);
                end
            end
            prev0[d] <= pwm_arr[d][0];
        end
    end

    // Wait for the next tick of DUT d; n = negedges waited.
    task automatic wait_win(input int d, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (tick_arr[d]) seen = 1'b1;
        end
        #1;
        check_eq($sformatf("tick_seen_d%0d", d), 32'(seen), 32'd1);
    endtask

    task automatic check_win(input int d, input string tag, input int e0, input int e1,
                             input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_ch%0d", tag, i), 32'(win[d][i]), 32'(e[i]));
        end
    endtask

    // Expected W=3 ramp values at successive boundaries with step_div=0.
    int tri_t [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5};

    initial begin
        int n;
        logic gap_pwm, gap_tick;

        b_rst = 1'b1; b_en = 1'b0; b_mode = '0; b_duty = '0; b_step = '0;
        s_rst = 1'b1; s_en = 1'b0; s_mode = '0; s_duty = '0; s_step = '0;
        repeat (3) @(negedge clk);
        check_eq("b_rst_pwm", 32'(b_pwm), 0);
        check_eq("b_rst_tick", 32'(b_tick), 0);
        check_eq("s_rst_pwm", 32'(s_pwm), 0);
        check_eq("s_rst_tick", 32'(s_tick), 0);

        // ch0 static 64, ch1 static 0, ch2 breathe, ch3 breathe-inverted, step every period
        b_mode = {2'b11, 2'b10, 2'b01, 2'b01};
        b_duty = {8'd0, 8'd0, 8'd0, 8'd64};
        b_step = 16'd0;
        b_en   = 1'b1;
        b_rst  = 1'b0;
        wait_win(0, n);
        check_eq("first_tick_delay", 32'(n), 32'd256);
        check_win(0, "pre_boundary", 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            wait_win(0, n);
            check_eq($sformatf("period_len_%0d", k), 32'(n), 32'd256);
            check_win(0, $sformatf("per%0d", k), 64, 0, k - 1, 256 - k);
            check_eq($sformatf("ch0_single_run_%0d", k), 32'(rise_win[0]), 32'd1);
        end

        // Mid-period change to duty 255 must wait for the next boundary.
        repeat (50) @(negedge clk);
        b_duty[15:8] = 8'd255;
        wait_win(0, n);
        check_win(0, "per4", 64, 0, 3, 252);
        wait_win(0, n);
        check_win(0, "per5", 64, 255, 4, 251);

        // Last enabled cycle has cnt=100; held value is 101 during the 50-cycle gap.
        repeat (101) @(negedge clk);
        b_en = 1'b0;
        gap_pwm = 1'b0;
        gap_tick = 1'b0;
        repeat (50) begin
            @(negedge clk);
            gap_pwm  = gap_pwm | (|b_pwm);
            gap_tick = gap_tick | b_tick;
        end
        check_eq("gap_pwm_low", 32'(gap_pwm), 0);
        check_eq("gap_no_tick", 32'(gap_tick), 0);
        b_en = 1'b1;
        wait_win(0, n);
        check_eq("tick_after_gap", 32'(n), 32'd155);
        check_win(0, "per6_gap", 64, 255, 5, 250);

        // Reset mid-period with en=1 (ch0 would be high at cnt=37); then step_div=3.
        repeat (37) @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_pwm", 32'(b_pwm), 0);
        check_eq("midrst_tick", 32'(b_tick), 0);
        b_step = 16'd3;
        b_rst  = 1'b0;
        wait_win(0, n);
        check_win(0, "div3_pre", 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            wait_win(0, n);
            check_eq($sformatf("div3_ch2_per%0d", k), 32'(win[0][2]), 32'((k - 1) / 4));
            check_eq($sformatf("div3_ch3_per%0d", k), 32'(win[0][3]), 32'(255 - (k - 1) / 4));
        end

        // step_div=10 until divcnt reaches 7, then lower to 2: step at the very next boundary.
        b_rst = 1'b1;
        @(negedge clk);
        b_step = 16'd10;
        b_rst  = 1'b0;
        wait_win(0, n);
        for (int k = 1; k <= 6; k++) begin
            wait_win(0, n);
        end
        check_eq("div10_ch2_per6", 32'(win[0][2]), 0);
        b_step = 16'd2;
        begin
            int exp_r [6];
            exp_r = '{0, 0, 1, 1, 1, 2};
            for (int k = 7; k <= 12; k++) begin
                wait_win(0, n);
                check_eq($sformatf("div_lower_ch2_per%0d", k), 32'(win[0][2]), 32'(exp_r[k - 7]));
            end
        end

        // W=3: ch0 breathe, ch1 inverted, ch2 static 7 (max), ch3 off with nonzero duty_in.
        s_mode = {2'b00, 2'b01, 2'b11, 2'b10};
        s_duty = {3'd5, 3'd7, 3'd0, 3'd0};
        s_step = 4'd0;
        s_en   = 1'b1;
        s_rst  = 1'b0;
        wait_win(1, n);
        check_eq("s_first_tick_delay", 32'(n), 32'd8);
        check_win(1, "s_pre", 0, 0, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            wait_win(1, n);
            check_win(1, $sformatf("s_per%0d", k), tri_t[k - 1], 7 - tri_t[k - 1], 7, 0);
        end

        // Ramp is now descending (r=3). Reset in the boundary cycle must win over the boundary.
        repeat (7) @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        check_eq("s_rst_bnd_tick", 32'(s_tick), 0);
        check_eq("s_rst_bnd_pwm", 32'(s_pwm), 0);
        s_rst = 1'b0;
        wait_win(1, n);
        check_eq("s_post_rst_delay", 32'(n), 32'd8);
        check_win(1, "s_post_rst_pre", 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            wait_win(1, n);
            check_win(1, $sformatf("s_restart%0d", k), k - 1, 8 - k, 7, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no summary, required finish before time limit");
        $fatal(1);
    end

endmodule
